// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence player: FSM states, ROM end codes
// and the tag/ROM read latency.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TAG_RD,
    TAG_WAIT,
    PLAY,
    PLAY_CHK
  } state_e;

  localparam logic [1:0] END_NONE  = 2'b00;
  localparam logic [1:0] END_SEQ   = 2'b01;
  localparam logic [1:0] END_CHAIN = 2'b10;
  localparam logic [1:0] END_RSVD  = 2'b11;

  localparam int unsigned RD_LAT = 1;

endpackage

// File: rtl/pb_edge_sync.sv
// Multi-stage synchroniser for an asynchronous push-button level, followed by
// a rising-edge detector producing one pulse per press.
module pb_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_async,
  output logic pb_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pb_async};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, keeping the shift chain intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pb_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/seq_player.sv
// Sequence player: button-selected sequence number, tag-RAM start lookup and
// step-driven waveform ROM playback with end/loop/chain codes.
module seq_player
  import seq_pkg::*;
#(
  parameter int SEQ_W       = 6,
  parameter int NUM_SEQ     = 64,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WRAP_SEQ    = 1,
  parameter int LOOP        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK_50,
  input  logic              reset_n,
  input  logic              pb_seq_up,
  input  logic              pb_seq_dn,
  input  logic              start,
  input  logic              stop,
  input  logic              step_en,
  output logic              tag_rd_en,
  output logic [SEQ_W-1:0]  tag_rd_addr,
  input  logic [ADDR_W-1:0] tag_rd_data,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [SEQ_W-1:0]  seq_num,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              playing,
  output logic              seq_done
);

  localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(NUM_SEQ - 1);

  function automatic logic [SEQ_W-1:0] seq_inc(input logic [SEQ_W-1:0] s);
    if (s == SEQ_MAX) return (WRAP_SEQ != 0) ? '0 : s;
    return s + 1'b1;
  endfunction

  function automatic logic [SEQ_W-1:0] seq_dec(input logic [SEQ_W-1:0] s);
    if (s == '0) return (WRAP_SEQ != 0) ? SEQ_MAX : s;
    return s - 1'b1;
  endfunction

  logic up_ev, dn_ev;

  pb_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_up (
    .clk(CLK_50), .rst_n(reset_n), .pb_async(pb_seq_up), .pb_rise(up_ev)
  );

  pb_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dn (
    .clk(CLK_50), .rst_n(reset_n), .pb_async(pb_seq_dn), .pb_rise(dn_ev)
  );

  state_e              state_q, state_d;
  logic [SEQ_W-1:0]    seq_num_q, seq_num_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                seq_done_q, seq_done_d;
  logic                tag_rd_en_q, tag_rd_en_d;
  logic                playing_q, playing_d;
  logic                btn_chg, end_seq;
  logic [SEQ_W-1:0]    chain_seq;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    state_d      = state_q;
    seq_num_d    = seq_num_q;
    rom_addr_d   = rom_addr_q;
    start_addr_d = start_addr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    seq_done_d   = 1'b0;
    rom_rd_en    = 1'b0;
    end_seq      = 1'b0;
    chain_seq    = seq_inc(seq_num_q);

    if (up_ev && !dn_ev)      seq_num_d = seq_inc(seq_num_q);
    else if (dn_ev && !up_ev) seq_num_d = seq_dec(seq_num_q);
    btn_chg = (seq_num_d != seq_num_q);

    if (stop) begin
      state_d = IDLE;
    end else if (btn_chg) begin
      // The word already fetched is still delivered; its end code is dropped.
      state_d = TAG_RD;
      if (state_q == PLAY_CHK) begin
        data_out_d   = rom_data;
        data_valid_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE:     if (start) state_d = TAG_RD;
        TAG_RD:   state_d = TAG_WAIT;
        TAG_WAIT: begin
          rom_addr_d   = tag_rd_data;
          start_addr_d = tag_rd_data;
          state_d      = PLAY;
        end
        PLAY: begin
          // Read strobe is combinational so the word is back after one cycle.
          if (step_en) begin
            rom_rd_en = 1'b1;
            state_d   = PLAY_CHK;
          end
        end
        PLAY_CHK: begin
          data_out_d   = rom_data;
          data_valid_d = 1'b1;
          case (rom_data[1:0])
            END_NONE: begin
              rom_addr_d = rom_addr_q + 1'b1;
              state_d    = PLAY;
            end
            END_CHAIN: begin
              if (chain_seq != seq_num_q) begin
                seq_num_d = chain_seq;
                state_d   = TAG_RD;
              end else begin
                end_seq = 1'b1;
              end
            end
            END_SEQ, END_RSVD: end_seq = 1'b1;
          endcase
          if (end_seq) begin
            if (LOOP != 0) begin
              rom_addr_d = start_addr_q;
              state_d    = PLAY;
            end else begin
              seq_done_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    tag_rd_en_d = (state_d == TAG_RD);
    playing_d   = (state_d != IDLE);
  end

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      seq_num_q    <= '0;
      rom_addr_q   <= '0;
      start_addr_q <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      seq_done_q   <= 1'b0;
      tag_rd_en_q  <= 1'b0;
      playing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_num_q    <= seq_num_d;
      rom_addr_q   <= rom_addr_d;
      start_addr_q <= start_addr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      seq_done_q   <= seq_done_d;
      tag_rd_en_q  <= tag_rd_en_d;
      playing_q    <= playing_d;
    end
  end

  assign tag_rd_en   = tag_rd_en_q;
  assign tag_rd_addr = seq_num_q;
  assign rom_addr    = rom_addr_q;
  assign seq_num     = seq_num_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign playing     = playing_q;
  assign seq_done    = seq_done_q;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player: three instances cover WRAP/LOOP settings,
// each backed by a one-cycle-latency tag RAM and ROM model.
module tb_seq_player;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] pb_up, pb_dn, start, stop, step_en;
  logic [2:0] tag_rd_en, rom_rd_en, data_valid, playing, seq_done;
  logic [5:0]  tag_rd_addr [3];
  logic [9:0]  rom_addr    [3];
  logic [5:0]  seq_num     [3];
  logic [31:0] data_out    [3];

  logic [9:0]  tag_mem [64];
  logic [31:0] rom_mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance 0: WRAP=1 LOOP=0; instance 1: WRAP=1 LOOP=1; instance 2: WRAP=0 LOOP=0.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [9:0]  tag_q;
    logic [31:0] rom_q;

    always @(posedge clk) begin
      if (tag_rd_en[g]) tag_q <= tag_mem[tag_rd_addr[g]];
      if (rom_rd_en[g]) rom_q <= rom_mem[rom_addr[g]];
    end

    seq_player #(
      .SEQ_W(6), .NUM_SEQ(64), .ADDR_W(10), .DATA_W(32),
      .WRAP_SEQ((g == 2) ? 0 : 1), .LOOP((g == 1) ? 1 : 0), .SYNC_STAGES(2)
    ) u_dut (
      .CLK_50(clk), .reset_n(reset_n),
      .pb_seq_up(pb_up[g]), .pb_seq_dn(pb_dn[g]),
      .start(start[g]), .stop(stop[g]), .step_en(step_en[g]),
      .tag_rd_en(tag_rd_en[g]), .tag_rd_addr(tag_rd_addr[g]), .tag_rd_data(tag_q),
      .rom_rd_en(rom_rd_en[g]), .rom_addr(rom_addr[g]), .rom_data(rom_q),
      .seq_num(seq_num[g]), .data_out(data_out[g]), .data_valid(data_valid[g]),
      .playing(playing[g]), .seq_done(seq_done[g])
    );
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int d, input logic up, input logic dn);
    pb_up[d] = up;
    pb_dn[d] = dn;
    cyc(4);
    pb_up[d] = 1'b0;
    pb_dn[d] = 1'b0;
    cyc(4);
  endtask

  task automatic pulse_stop(input int d);
    stop[d] = 1'b1;
    cyc(1);
    stop[d] = 1'b0;
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    cyc(1);
    start[d] = 1'b0;
  endtask

  task automatic step(input int d);
    step_en[d] = 1'b1;
    cyc(1);
    step_en[d] = 1'b0;
    cyc(1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tag_mem[i] = 10'h000;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 32'h0;
    tag_mem[2]  = 10'h040;
    tag_mem[5]  = 10'h123;
    tag_mem[63] = 10'h100;
    tag_mem[0]  = 10'h3FF;
    rom_mem[10'h040] = 32'hAAAA_0000;
    rom_mem[10'h041] = 32'h5555_0004;
    rom_mem[10'h042] = 32'h1234_5671;
    rom_mem[10'h100] = 32'hCAFE_0002;
    rom_mem[10'h3FF] = 32'hBEEF_0000;
    rom_mem[10'h000] = 32'h0000_0F00;

    reset_n = 1'b0;
    pb_up = '0; pb_dn = '0; start = '0; stop = '0; step_en = '0;
    cyc(2);
    check("rst_seq_num",  32'(seq_num[0]), 0);
    check("rst_rom_addr", 32'(rom_addr[0]), 0);
    check("rst_playing",  32'(playing[0]), 0);
    reset_n = 1'b1;
    cyc(2);

    // First up press: seq_num moves on the third edge after the raw edge.
    pb_up[0] = 1'b1;
    cyc(2);
    check("up_lat_early", 32'(seq_num[0]), 0);
    cyc(1);
    check("up_lat_seq1",  32'(seq_num[0]), 1);
    check("idle_chg_tag_rd", 32'(tag_rd_en[0]), 1);
    check("idle_chg_tag_addr", 32'(tag_rd_addr[0]), 1);
    check("idle_chg_playing", 32'(playing[0]), 1);
    cyc(1);
    check("tag_rd_one_cycle", 32'(tag_rd_en[0]), 0);
    pb_up[0] = 1'b0;
    cyc(4);
    press(0, 1'b1, 1'b0); check("up_seq2", 32'(seq_num[0]), 2);
    press(0, 1'b1, 1'b0); check("up_seq3", 32'(seq_num[0]), 3);
    press(0, 1'b0, 1'b1); check("dn_seq2", 32'(seq_num[0]), 2);
    pulse_stop(0);
    check("stop_idle", 32'(playing[0]), 0);

    // Seq 2 from 0x040: two plain words then an end-of-sequence word.
    pulse_start(0);
    check("start_tag_rd",   32'(tag_rd_en[0]), 1);
    check("start_tag_addr", 32'(tag_rd_addr[0]), 2);
    cyc(2);
    check("start_rom_addr", 32'(rom_addr[0]), 32'h040);
    step_en[0] = 1'b1;
    cyc(RD_LAT);
    step_en[0] = 1'b0;
    check("step_lat_early", 32'(data_valid[0]), 0);
    cyc(1);
    check("w0_valid",    32'(data_valid[0]), 1);
    check("w0_data",     data_out[0], 32'hAAAA_0000);
    check("w0_rom_addr", 32'(rom_addr[0]), 32'h041);
    step_en[0] = 1'b1;
    cyc(2);
    step_en[0] = 1'b0;
    check("w1_data",     data_out[0], 32'h5555_0004);
    check("w1_rom_addr", 32'(rom_addr[0]), 32'h042);
    cyc(1);
    check("b2b_tick_dropped", 32'(data_valid[0]), 0);
    step(0);
    check("w2_data",     data_out[0], 32'h1234_5671);
    check("w2_seq_done", 32'(seq_done[0]), 1);
    check("w2_idle",     32'(playing[0]), 0);
    check("w2_rom_hold", 32'(rom_addr[0]), 32'h042);
    cyc(1);
    check("seq_done_pulse", 32'(seq_done[0]), 0);

    // Move to seq 5, then assert reset asynchronously mid-cycle.
    press(0, 1'b1, 1'b0);
    press(0, 1'b1, 1'b0);
    press(0, 1'b1, 1'b0);
    check("pre_rst_seq5", 32'(seq_num[0]), 5);
    check("pre_rst_rom",  32'(rom_addr[0]), 32'h123);
    reset_n = 1'b0;
    #1;
    check("async_rst_seq",  32'(seq_num[0]), 0);
    check("async_rst_rom",  32'(rom_addr[0]), 0);
    check("async_rst_data", data_out[0], 0);
    check("async_rst_play", 32'(playing[0]), 0);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);

    press(0, 1'b0, 1'b1); check("dn_wrap_63", 32'(seq_num[0]), 63);
    press(0, 1'b1, 1'b1); check("up_dn_same", 32'(seq_num[0]), 63);
    pulse_stop(0);

    // Chain from seq 63 wraps to seq 0, whose start address is 0x3FF.
    pulse_start(0);
    cyc(2);
    check("chain_rom_addr", 32'(rom_addr[0]), 32'h100);
    step(0);
    check("chain_data",     data_out[0], 32'hCAFE_0002);
    check("chain_seq_wrap", 32'(seq_num[0]), 0);
    check("chain_no_done",  32'(seq_done[0]), 0);
    check("chain_tag_rd",   32'(tag_rd_en[0]), 1);
    check("chain_tag_addr", 32'(tag_rd_addr[0]), 0);
    cyc(2);
    check("chain_start_3ff", 32'(rom_addr[0]), 32'h3FF);
    step(0);
    check("addr_wrap_data", data_out[0], 32'hBEEF_0000);
    check("addr_wrap_000",  32'(rom_addr[0]), 32'h000);

    // Up press lands on PLAY_CHK: word delivered, end code discarded, re-read.
    pb_up[0] = 1'b1;
    cyc(1);
    step_en[0] = 1'b1;
    cyc(1);
    step_en[0] = 1'b0;
    cyc(1);
    check("coinc_valid",    32'(data_valid[0]), 1);
    check("coinc_data",     data_out[0], 32'h0000_0F00);
    check("coinc_seq",      32'(seq_num[0]), 1);
    check("coinc_tag_rd",   32'(tag_rd_en[0]), 1);
    check("coinc_tag_addr", 32'(tag_rd_addr[0]), 1);
    check("coinc_rom_hold", 32'(rom_addr[0]), 32'h000);
    pb_up[0] = 1'b0;
    cyc(4);
    pulse_stop(0);

    // LOOP=1 instance: seq 2 restarts at 0x040 with no seq_done.
    press(1, 1'b1, 1'b0);
    press(1, 1'b1, 1'b0);
    pulse_stop(1);
    pulse_start(1);
    cyc(2);
    check("loop_start", 32'(rom_addr[1]), 32'h040);
    step(1);
    step(1);
    step(1);
    check("loop_w2_data",  data_out[1], 32'h1234_5671);
    check("loop_no_done",  32'(seq_done[1]), 0);
    check("loop_restart",  32'(rom_addr[1]), 32'h040);
    check("loop_playing",  32'(playing[1]), 1);
    step(1);
    check("loop_again",    data_out[1], 32'hAAAA_0000);
    step_en[1] = 1'b1;
    cyc(1);
    step_en[1] = 1'b0;
    stop[1] = 1'b1;
    cyc(1);
    stop[1] = 1'b0;
    check("stop_no_valid", 32'(data_valid[1]), 0);
    check("stop_idle",     32'(playing[1]), 0);
    check("stop_rom_hold", 32'(rom_addr[1]), 32'h041);
    step(1);
    cyc(1);
    check("stop_step_ignored", 32'(data_valid[1]), 0);

    // WRAP=0 instance: saturating counter and a chain that cannot advance.
    press(2, 1'b0, 1'b1); check("sat_dn_at_0", 32'(seq_num[2]), 0);
    for (int i = 0; i < 63; i++) press(2, 1'b1, 1'b0);
    check("sat_reach_63", 32'(seq_num[2]), 63);
    press(2, 1'b1, 1'b0); check("sat_up_at_63", 32'(seq_num[2]), 63);
    pulse_stop(2);
    pulse_start(2);
    cyc(2);
    check("sat_chain_start", 32'(rom_addr[2]), 32'h100);
    step(2);
    check("sat_chain_valid", 32'(data_valid[2]), 1);
    check("sat_chain_seq",   32'(seq_num[2]), 63);
    check("sat_chain_done",  32'(seq_done[2]), 1);
    check("sat_chain_idle",  32'(playing[2]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_player.md
Name: seq_player

Overview:
Parametrised successor to the current sequencer. It selects a sequence number with the up/down push-buttons, fetches that sequence's start address from the tag RAM, and steps through waveform ROM words on a step-enable tick. Playback ends, loops or chains on an end code held in each ROM word. It runs in a single CLK_50 domain; the old slow_clk becomes a step_en strobe. It sits between the push-button logic and the ROM/tag-RAM pair.

Parameters:
SEQ_W, 6, width of the sequence number.
NUM_SEQ, 64, number of valid sequences (0..NUM_SEQ-1); must be ≤ 2**SEQ_W.
ADDR_W, 10, ROM address width.
DATA_W, 32, ROM word width; bits [1:0] hold the end code.
WRAP_SEQ, 1, 1 = seq_num wraps at the ends of its range, 0 = saturates.
LOOP, 0, 1 = on end code, restart the current sequence; 0 = stop.
SYNC_STAGES, 2, button synchroniser depth (≥ 2).

Ports:
CLK_50  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
pb_seq_up  in  1  raw button, async, level.
pb_seq_dn  in  1  raw button, async, level.
start  in  1  pulse: start the selected sequence.
stop  in  1  pulse: abort playback.
step_en  in  1  one-cycle playback tick.
tag_rd_en  out  1  tag RAM read strobe.
tag_rd_addr  out  SEQ_W  tag RAM address (= seq_num).
tag_rd_data  in  ADDR_W  sequence start address, valid 1 cycle after tag_rd_en.
rom_rd_en  out  1  ROM read strobe.
rom_addr  out  ADDR_W  ROM address.
rom_data  in  DATA_W  ROM word, valid 1 cycle after rom_rd_en.
seq_num  out  SEQ_W  selected sequence.
data_out  out  DATA_W  last ROM word played.
data_valid  out  1  1-cycle pulse when data_out updates.
playing  out  1  high in TAG_RD..PLAY_CHK.
seq_done  out  1  1-cycle pulse on end of a non-looping sequence.

Behaviour:
- Reset (async assert, sync release): seq_num=0, rom_addr=0, data_out=0, all strobes/flags 0, state IDLE, synchronisers cleared.
- Buttons pass through the SYNC_STAGES synchroniser, then rising-edge detect. This gives one up/dn event per press; a held button does not auto-repeat.
- up-only event: seq_num+1; at NUM_SEQ-1 → 0 (WRAP_SEQ=1) or hold (0). dn-only event: seq_num-1; at 0 → NUM_SEQ-1 or hold. up and dn in the same cycle: no change.
- seq_num updates SYNC_STAGES+1 cycles after the raw press edge.
- States: IDLE, TAG_RD, TAG_WAIT, PLAY, PLAY_CHK.
- IDLE: on start or any seq_num change → TAG_RD.
- TAG_RD: tag_rd_en=1 for 1 cycle, tag_rd_addr=seq_num → TAG_WAIT.
- TAG_WAIT: rom_addr ← tag_rd_data; start_addr register ← tag_rd_data → PLAY.
- PLAY: on step_en, rom_rd_en=1 for 1 cycle → PLAY_CHK. step_en outside PLAY is ignored.
- PLAY_CHK: data_out ← rom_data, data_valid=1. Action by rom_data[1:0]:
  - 00: rom_addr+1, wrapping 2**ADDR_W-1 → 0 → PLAY.
  - 01: if LOOP=1, rom_addr ← start_addr → PLAY; else seq_done=1 → IDLE.
  - 10 (chain): seq_num advances as an up event, honouring WRAP_SEQ; if saturated with no advance, treat as 01 → otherwise TAG_RD.
  - 11: treated as 01.
- stop in any state → IDLE next cycle. No data_valid or seq_done is produced; rom_addr holds.
- A seq_num change while in TAG_WAIT..PLAY_CHK aborts and re-enters TAG_RD next cycle. If it coincides with PLAY_CHK, data_valid for that word still fires and the end code is discarded.
- stop coincident with start or a seq change: stop wins.
- Step latency: step_en → data_valid = 2 cycles. Back-to-back step_en: a second tick arriving in PLAY_CHK is dropped; the maximum step rate is every 2 cycles.

Decomposition:
- Package seq_pkg holds: the state enum, end-code constants (END_NONE=2'b00, END_SEQ=2'b01, END_CHAIN=2'b10, END_RSVD=2'b11), and the TAG/ROM read latency constant (1).
- One sub-module, pb_edge_sync: parametrised SYNC_STAGES synchroniser plus rising-edge pulse, instantiated once per button.

Test Plan:
- Reset with seq_num previously 5 → seq_num=0, all outputs 0, state IDLE within 0 cycles of reset_n low.
- Three up presses, then one dn press (WRAP_SEQ=1) → seq_num 1,2,3,2. A dn press from 0 → 63. A simultaneous up+dn press → unchanged.
- start with seq 2, tag_rd_data=0x040, ROM words [0x40]=…00, [0x41]=…00, [0x42]=…01, LOOP=0 → tag_rd_addr=2, rom_addr 0x40,0x41,0x42, three data_valid pulses, seq_done once, then IDLE.
- Same sequence with LOOP=1 → after 0x42, rom_addr returns to 0x40 and no seq_done. stop in mid-play → IDLE next cycle, rom_addr held, no further data_valid.
- Word [0x42]=…10 with seq 63 and WRAP_SEQ=0 → seq_num stays 63, seq_done asserted. With WRAP_SEQ=1 → seq_num=0 and a new tag read at address 0.
- ROM start address 0x3FF with end code 00 → rom_addr wraps to 0x000. An up press during PLAY_CHK → data_valid fires, then TAG_RD for the new seq_num.
